// File: rtl/fp_post_normalizer.sv
// Post-add normalizer and round-to-nearest-even for the single-precision adder.
// Ports: in_valid/in_ready + sign_in/exp_in/mantis_in in; out_valid/out_ready + sign/exp/frac/zero/ovf out.
module fp_post_normalizer #(
  parameter int STEP_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [27:0] mantis_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [7:0]  exp_out,
  output logic [22:0] frac_out,
  output logic        zero_out,
  output logic        ovf_out
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t state, state_n;

  logic        sign_r, sign_n;
  logic [8:0]  exp_r, exp_n;
  logic [27:0] mant_r, mant_n;
  logic        zero_r, zero_n;

  logic        out_valid_n;
  logic        sign_out_n;
  logic [7:0]  exp_out_n;
  logic [22:0] frac_out_n;
  logic        zero_out_n;
  logic        ovf_out_n;

  // Zeros between bit 25 and the first set bit (26 if none).
  function automatic logic [4:0] lzc26(input logic [25:0] v);
    lzc26 = 5'd26;
    for (int i = 0; i < 26; i++) begin
      if (v[i]) lzc26 = 5'(25 - i);
    end
  endfunction

  // Left-shift amount for one NORM step, clamped so exp never drops below 1.
  logic [4:0] lz;
  logic [8:0] step;

  always_comb begin
    lz   = lzc26(mant_r[25:0]);
    step = {4'd0, lz} + 9'd1;
    if (step > 9'(STEP_MAX)) step = 9'(STEP_MAX);
    if (step > exp_r - 9'd1) step = exp_r - 9'd1;
  end

  // Rounding datapath; m[27] is always clear by the time ROUND runs.
  logic        rnd_up;
  logic [24:0] rsum;
  logic [24:0] rnorm;
  logic [8:0]  rexp;
  logic [8:0]  field;

  always_comb begin
    rnd_up = mant_r[2] & (mant_r[3] | mant_r[1] | mant_r[0]);
    rsum   = mant_r[27:3] + {24'd0, rnd_up};
    rnorm  = rsum;
    rexp   = exp_r;
    if (rsum[24]) begin
      rnorm = rsum >> 1;
      rexp  = exp_r + 9'd1;
    end
    field = rnorm[23] ? rexp : 9'd0;
  end

  always_comb begin
    state_n     = state;
    sign_n      = sign_r;
    exp_n       = exp_r;
    mant_n      = mant_r;
    zero_n      = zero_r;
    out_valid_n = out_valid;
    sign_out_n  = sign_out;
    exp_out_n   = exp_out;
    frac_out_n  = frac_out;
    zero_out_n  = zero_out;
    ovf_out_n   = ovf_out;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          sign_n  = sign_in;
          exp_n   = (exp_in == 8'd0) ? 9'd1 : {1'b0, exp_in};
          mant_n  = mantis_in;
          zero_n  = 1'b0;
          state_n = NORM;
        end
      end
      NORM: begin
        if (mant_r == 28'd0) begin
          zero_n  = 1'b1;
          state_n = ROUND;
        end else if (mant_r[27]) begin
          // Keep the shifted-out bit alive in sticky.
          mant_n  = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
          exp_n   = exp_r + 9'd1;
          state_n = ROUND;
        end else if (mant_r[26]) begin
          state_n = ROUND;
        end else if (exp_r == 9'd1) begin
          state_n = ROUND;
        end else begin
          mant_n = mant_r << step[3:0];
          exp_n  = exp_r - step;
        end
      end
      ROUND: begin
        sign_out_n  = sign_r;
        zero_out_n  = zero_r;
        ovf_out_n   = 1'b0;
        exp_out_n   = field[7:0];
        frac_out_n  = rnorm[22:0];
        if (zero_r) begin
          exp_out_n  = 8'd0;
          frac_out_n = 23'd0;
        end else if (field >= 9'd255) begin
          exp_out_n  = 8'd255;
          frac_out_n = 23'd0;
          ovf_out_n  = 1'b1;
        end
        out_valid_n = 1'b1;
        state_n     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sign_r    <= 1'b0;
      exp_r     <= 9'd0;
      mant_r    <= 28'd0;
      zero_r    <= 1'b0;
      out_valid <= 1'b0;
      sign_out  <= 1'b0;
      exp_out   <= 8'd0;
      frac_out  <= 23'd0;
      zero_out  <= 1'b0;
      ovf_out   <= 1'b0;
    end else begin
      state     <= state_n;
      sign_r    <= sign_n;
      exp_r     <= exp_n;
      mant_r    <= mant_n;
      zero_r    <= zero_n;
      out_valid <= out_valid_n;
      sign_out  <= sign_out_n;
      exp_out   <= exp_out_n;
      frac_out  <= frac_out_n;
      zero_out  <= zero_out_n;
      ovf_out   <= ovf_out_n;
    end
  end

  assign in_ready = (state == IDLE);

endmodule

// File: tb/tb_fp_post_normalizer.sv
// Bench for fp_post_normalizer: vector table, scoreboard queue, backpressure and reset.
// Drives at negedge, samples 1ns after posedge.
module tb_fp_post_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] mantis_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] frac_out;
  logic        zero_out;
  logic        ovf_out;

  fp_post_normalizer #(.STEP_MAX(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sign_in(sign_in),
    .exp_in(exp_in),
    .mantis_in(mantis_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sign_out(sign_out),
    .exp_out(exp_out),
    .frac_out(frac_out),
    .zero_out(zero_out),
    .ovf_out(ovf_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    int          lat;
    logic [7:0]  eo;
    logic [22:0] fo;
    logic        zo;
    logic        ov;
  } vec_t;

  vec_t vt[15];
  vec_t sb[$];
  int   pass_cnt = 0;
  int   total    = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_op(input vec_t t, input int hold);
    int   n;
    logic got;
    vec_t e;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    sign_in   = t.s;
    exp_in    = t.e;
    mantis_in = t.m;
    in_valid  = 1'b1;
    sb.push_back(t);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) chk("busy_in_ready", in_ready, 0);
      got = out_valid;
    end
    if (!got) begin
      chk("timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk("latency", n, e.lat);
      chk("sign", sign_out, e.s);
      chk("exp", exp_out, e.eo);
      chk("frac", frac_out, e.fo);
      chk("zero", zero_out, e.zo);
      chk("ovf", ovf_out, e.ov);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_exp", exp_out, e.eo);
        chk("hold_frac", frac_out, e.fo);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("released", out_valid, 0);
    chk("back_idle", in_ready, 1);
  endtask

  initial begin
    vt[0]  = '{1'b0, 8'd127, 28'h4000000, 2, 8'd127, 23'h000000, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'd130, 28'h8000008, 2, 8'd131, 23'h000000, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'd130, 28'h8000018, 2, 8'd131, 23'h000002, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'd100, 28'h0000400, 6, 8'd84,  23'h000000, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 8'd3,   28'h0100000, 3, 8'd0,   23'h080000, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 8'd254, 28'h7FFFFFC, 2, 8'd255, 23'h000000, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 8'd50,  28'h0000000, 2, 8'd0,   23'h000000, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 8'd255, 28'h8000000, 2, 8'd255, 23'h000000, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 8'd0,   28'h0000008, 2, 8'd0,   23'h000001, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'd1,   28'h3FFFFFC, 2, 8'd1,   23'h000000, 1'b0, 1'b0};
    vt[10] = '{1'b1, 8'd10,  28'h400000C, 2, 8'd10,  23'h000002, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'd10,  28'h4000005, 2, 8'd10,  23'h000001, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'd20,  28'h2000000, 3, 8'd19,  23'h000000, 1'b0, 1'b0};
    vt[13] = '{1'b0, 8'd10,  28'h800000D, 2, 8'd11,  23'h000001, 1'b0, 1'b0};
    vt[14] = '{1'b1, 8'd5,   28'h0000400, 3, 8'd0,   23'h000800, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sign_in   = 1'b0;
    exp_in    = 8'd0;
    mantis_in = 28'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_exp", exp_out, 0);
    chk("rst_frac", frac_out, 0);
    chk("rst_flags", {sign_out, zero_out, ovf_out}, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_op(vt[i], 0);

    run_op(vt[0], 5);

    // Reset in the middle of a long normalization.
    @(negedge clk);
    sign_in   = vt[3].s;
    exp_in    = vt[3].e;
    mantis_in = vt[3].m;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("norm_busy", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("discarded", out_valid, 0);
    end
    run_op(vt[2], 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
